// File: rtl/bcd_scan_pkg.sv
// rtl/bcd_scan_pkg.sv - shared state encoding and widths for the BCD scan controller
package bcd_scan_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DWELL = 2'd1;
   localparam logic [1:0] BLANK = 2'd2;

   localparam int DEC_W   = 10;
   localparam int BCD_W   = 4;
   localparam int BCD_MAX = 9;

endpackage

// File: rtl/bcd_to_decimal.sv
// rtl/bcd_to_decimal.sv - gate-level 4-bit BCD to one-hot decimal decoder
module bcd_to_decimal (
   input  logic [3:0] bcd_i,
   output logic [9:0] dec_o
);

   logic [3:0] n;
   assign n = ~bcd_i;

   // Full minterms, so codes 10..15 decode to all-zero.
   assign dec_o[0] = n[3]     & n[2]     & n[1]     & n[0];
   assign dec_o[1] = n[3]     & n[2]     & n[1]     & bcd_i[0];
   assign dec_o[2] = n[3]     & n[2]     & bcd_i[1] & n[0];
   assign dec_o[3] = n[3]     & n[2]     & bcd_i[1] & bcd_i[0];
   assign dec_o[4] = n[3]     & bcd_i[2] & n[1]     & n[0];
   assign dec_o[5] = n[3]     & bcd_i[2] & n[1]     & bcd_i[0];
   assign dec_o[6] = n[3]     & bcd_i[2] & bcd_i[1] & n[0];
   assign dec_o[7] = n[3]     & bcd_i[2] & bcd_i[1] & bcd_i[0];
   assign dec_o[8] = bcd_i[3] & n[2]     & n[1]     & n[0];
   assign dec_o[9] = bcd_i[3] & n[2]     & n[1]     & bcd_i[0];

endmodule

// File: rtl/bcd_scan_ctrl.sv
// rtl/bcd_scan_ctrl.sv - double-buffered multiplexed BCD digit scanner with blanking
module bcd_scan_ctrl
   import bcd_scan_pkg::*;
#(
   parameter int NDIG      = 4,
   parameter int DWELL_CYC = 8,
   parameter int BLANK_CYC = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                load_valid,
   output logic                load_ready,
   input  logic [4*NDIG-1:0]   load_digits,
   output logic [DEC_W-1:0]    dec_out,
   output logic [NDIG-1:0]     digit_sel,
   output logic                bcd_err,
   output logic                frame_done
);

   localparam int MAX_DB = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
   localparam int MAX_P  = (MAX_DB > NDIG) ? MAX_DB : NDIG;
   localparam int CNT_W  = $clog2(MAX_P + 1);
   localparam int IDX_W  = $clog2(NDIG);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(((BLANK_CYC > 0) ? BLANK_CYC : 1) - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);

   logic [1:0]         state_q, state_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [4*NDIG-1:0]  active_q, active_d;
   logic [4*NDIG-1:0]  pend_q, pend_d;
   logic               pend_full_q, pend_full_d;
   logic               loaded_q, loaded_d;
   logic               load_ready_q;
   logic [DEC_W-1:0]   dec_out_q;
   logic [NDIG-1:0]    digit_sel_q;
   logic               bcd_err_q, frame_done_q;

   logic               adv, xfer, frame_done_d;
   logic [BCD_W-1:0]   cur_digit;
   logic [DEC_W-1:0]   dec_raw;

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      active_d    = active_q;
      pend_d      = pend_q;
      pend_full_d = pend_full_q;
      loaded_d    = loaded_q;
      adv         = 1'b0;
      xfer        = 1'b0;

      case (state_q)
         IDLE: begin
            if (en && (pend_full_q || loaded_q)) begin
               state_d = DWELL;
               idx_d   = '0;
               cnt_d   = '0;
               xfer    = pend_full_q;
            end
         end
         DWELL: begin
            if (cnt_q == DWELL_LAST) begin
               cnt_d = '0;
               if (BLANK_CYC > 0) state_d = BLANK;
               else               adv     = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               cnt_d = '0;
               adv   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // en only matters here at the frame boundary; mid-frame it is ignored.
      if (adv) begin
         if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (en) begin
               state_d = DWELL;
               xfer    = pend_full_q;
            end else begin
               state_d = IDLE;
            end
         end else begin
            idx_d   = idx_q + 1'b1;
            state_d = DWELL;
         end
      end

      if (xfer) begin
         active_d    = pend_q;
         pend_full_d = 1'b0;
         loaded_d    = 1'b1;
      end
      if (load_valid && load_ready_q) begin
         pend_d      = load_digits;
         pend_full_d = 1'b1;
      end
   end

   always_comb begin
      cur_digit = '0;
      for (int i = 0; i < NDIG; i++) begin
         if (idx_d == IDX_W'(i)) cur_digit = active_d[4*i +: BCD_W];
      end
   end

   bcd_to_decimal u_dec (
      .bcd_i (cur_digit),
      .dec_o (dec_raw)
   );

   // Outputs are registered from next-state so they line up with the DWELL cycles.
   assign frame_done_d = (idx_d == IDX_LAST) &&
                         (((BLANK_CYC > 0) && (state_d == BLANK) && (cnt_d == BLANK_LAST)) ||
                          ((BLANK_CYC == 0) && (state_d == DWELL) && (cnt_d == DWELL_LAST)));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         active_q     <= '0;
         pend_q       <= '0;
         pend_full_q  <= 1'b0;
         loaded_q     <= 1'b0;
         load_ready_q <= 1'b1;
         dec_out_q    <= '0;
         digit_sel_q  <= '0;
         bcd_err_q    <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         active_q     <= active_d;
         pend_q       <= pend_d;
         pend_full_q  <= pend_full_d;
         loaded_q     <= loaded_d;
         load_ready_q <= ~pend_full_d;
         frame_done_q <= frame_done_d;
         if (state_d == DWELL) begin
            digit_sel_q <= NDIG'(1) << idx_d;
            bcd_err_q   <= (cur_digit > BCD_W'(BCD_MAX));
            dec_out_q   <= (cur_digit > BCD_W'(BCD_MAX)) ? '0 : dec_raw;
         end else begin
            digit_sel_q <= '0;
            bcd_err_q   <= 1'b0;
            dec_out_q   <= '0;
         end
      end
   end

   assign load_ready = load_ready_q;
   assign dec_out    = dec_out_q;
   assign digit_sel  = digit_sel_q;
   assign bcd_err    = bcd_err_q;
   assign frame_done = frame_done_q;

endmodule
